// File: rtl/la_bus_initiator_if.sv
// Request/ready bus between la_bus_initiator (master) and a responder (slave).
interface la_bus_initiator_if #(
    parameter int BITS = 32
);
    logic            valid;
    logic [3:0]      wstrb;
    logic [BITS-1:0] wdata;
    logic            ready;
    logic [BITS-1:0] rdata;

    modport master (output valid, wstrb, wdata, input  ready, rdata);
    modport slave  (input  valid, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/la_bus_initiator.sv
// Burst bus initiator: one command becomes cmd_len+1 request beats separated by a one-cycle gap.
// Optional REQ timeout abort is enabled by defining LA_BUS_INITIATOR_TIMEOUT_EN.
module la_bus_initiator #(
    parameter int BITS           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_start,
    input  logic [3:0]              cmd_wstrb,
    input  logic [BITS-1:0]         cmd_wdata,
    input  logic [3:0]              cmd_len,
    la_bus_initiator_if.master      bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [BITS-1:0]         last_rdata,
    output logic [4:0]              beats_done
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_wstrb;
    logic [BITS-1:0] r_wdata;
    logic [3:0]      r_len;
    logic [4:0]      r_beats;
    logic            r_done;
    logic            r_err;
    logic [BITS-1:0] r_last_rdata;

    logic w_accept;
    logic w_beat;
    logic w_final;
    logic w_tmo;

    assign w_accept = (r_state == S_IDLE) && cmd_start;
    assign w_beat   = (r_state == S_REQ) && bus.ready;
    // r_beats still holds the pre-increment count, so equality with cmd_len marks the last beat
    assign w_final  = w_beat && (r_beats == {1'b0, r_len});

`ifdef LA_BUS_INITIATOR_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_tcnt;

    // Cleared outside REQ so every REQ entry starts counting from zero
    always_ff @(posedge clk) begin
        if (reset)
            r_tcnt <= '0;
        else if (r_state != S_REQ || bus.ready || w_tmo)
            r_tcnt <= '0;
        else
            r_tcnt <= r_tcnt + 8'd1;
    end

    assign w_tmo = (r_state == S_REQ) && !bus.ready && (r_tcnt == TMO_LAST);
`else
    // Legal TIMEOUT_CYCLES is 2..255, so this is constant low: no abort path
    assign w_tmo = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (w_beat)
                    w_next = w_final ? S_IDLE : S_GAP;
                else if (w_tmo)
                    w_next = S_IDLE;
            end
            S_GAP:   w_next = S_REQ;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.valid = 1'b0;
        bus.wstrb = '0;
        bus.wdata = '0;
        busy      = 1'b0;
        case (r_state)
            S_REQ: begin
                bus.valid = 1'b1;
                bus.wstrb = r_wstrb;
                bus.wdata = r_wdata;
                busy      = 1'b1;
            end
            S_GAP:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstrb      <= '0;
            r_wdata      <= '0;
            r_len        <= '0;
            r_beats      <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_last_rdata <= '0;
        end else begin
            r_done <= w_final || w_tmo;
            if (w_accept) begin
                r_wstrb <= cmd_wstrb;
                r_wdata <= cmd_wdata;
                r_len   <= cmd_len;
                r_beats <= '0;
                r_err   <= 1'b0;
            end
            if (w_beat) begin
                r_last_rdata <= bus.rdata;
                r_beats      <= r_beats + 5'd1;
                if (!w_final)
                    r_wdata <= r_wdata + {{(BITS-1){1'b0}}, 1'b1};
            end
            if (w_tmo)
                r_err <= 1'b1;
        end
    end

    assign done       = r_done;
    assign err        = r_err;
    assign last_rdata = r_last_rdata;
    assign beats_done = r_beats;

endmodule

// File: tb/tb_la_bus_initiator.sv
// Directed bench for la_bus_initiator: table of commands plus timeout/robustness sequences.
module tb_la_bus_initiator;
    localparam int BITS = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic [3:0]  cmd_wstrb;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_len;
    logic        busy, done, err;
    logic [31:0] last_rdata;
    logic [4:0]  beats_done;

    int checks   = 0;
    int failures = 0;

    la_bus_initiator_if #(.BITS(BITS)) bus();

    la_bus_initiator #(.BITS(BITS), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_start  (cmd_start),
        .cmd_wstrb  (cmd_wstrb),
        .cmd_wdata  (cmd_wdata),
        .cmd_len    (cmd_len),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .last_rdata (last_rdata),
        .beats_done (beats_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [3:0]  len;
        int          dly;
        logic [31:0] rbase;
        logic [4:0]  exp_beats;
        logic [31:0] exp_last;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Acts as the responder: ready after dly extra REQ cycles, rdata = rbase + beat index
    task automatic run_cmd(input vec_t v, input bit poke, input string tag);
        int beat = 0;
        int rc   = 0;
        int gap  = 0;
        bit fin  = 0;
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_wstrb = v.wstrb;
        cmd_wdata = v.wdata;
        cmd_len   = v.len;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            bus.ready = 1'b0;
            bus.rdata = 32'hDEAD_BEEF;
            cmd_start = poke && (c == 1);
            if (poke && c == 1) begin
                cmd_wstrb = 4'h0;
                cmd_len   = 4'hF;
                cmd_wdata = 32'hFFFF_FFFF;
            end
            if (c == 0) chk({tag, "_err_cleared"}, 32'(err), 32'h0);
            if (done) begin
                fin = 1;
            end else if (bus.valid) begin
                if (rc == 0) begin
                    chk({tag, "_wdata"}, bus.wdata, v.wdata + 32'(beat));
                    chk({tag, "_wstrb"}, 32'(bus.wstrb), 32'(v.wstrb));
                    if (beat > 0) chk({tag, "_gap_len"}, 32'(gap), 32'd1);
                end
                if (rc == v.dly) begin
                    bus.ready = 1'b1;
                    bus.rdata = v.rbase + 32'(beat);
                    beat++;
                    rc  = 0;
                    gap = 0;
                end else begin
                    rc++;
                end
            end else begin
                gap++;
                chk({tag, "_idle_bus"}, 32'(bus.wstrb) | bus.wdata, 32'h0);
            end
        end
        cmd_start = 1'b0;
        chk({tag, "_done_seen"}, 32'(fin), 32'd1);
        chk({tag, "_beats_seen"}, 32'(beat), 32'(v.exp_beats));
        chk({tag, "_beats_done"}, 32'(beats_done), 32'(v.exp_beats));
        chk({tag, "_last_rdata"}, last_rdata, v.exp_last);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'h0);
        if (poke) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk({tag, "_no_extra_beat"}, 32'(bus.valid) | 32'(busy), 32'h0);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
        chk({tag, "_wstrb"}, 32'(bus.wstrb), 32'h0);
        chk({tag, "_wdata"}, bus.wdata, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_last_rdata"}, last_rdata, 32'h0);
        chk({tag, "_beats_done"}, 32'(beats_done), 32'h0);
    endtask

    initial begin
        tbl[0] = '{4'hF, 32'h1234_5678, 4'd0,  1, 32'h0000_0000, 5'd1,  32'h0000_0000};
        tbl[1] = '{4'h0, 32'hCAFE_0000, 4'd0,  0, 32'h0000_00A5, 5'd1,  32'h0000_00A5};
        tbl[2] = '{4'hF, 32'hFFFF_FFFE, 4'd3,  0, 32'h0000_0100, 5'd4,  32'h0000_0103};
        tbl[3] = '{4'h3, 32'h0000_0000, 4'd15, 2, 32'h0000_5000, 5'd16, 32'h0000_500F};
        tbl[4] = '{4'hC, 32'h0000_00FF, 4'd1,  2, 32'h0000_0040, 5'd2,  32'h0000_0041};

        // Reset with cmd_start and ready held high: reset must win
        reset     = 1'b1;
        cmd_start = 1'b1;
        cmd_wstrb = 4'hF;
        cmd_wdata = 32'h1111_1111;
        cmd_len   = 4'd3;
        bus.ready = 1'b1;
        bus.rdata = 32'h5555_5555;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst");
        reset     = 1'b0;
        cmd_start = 1'b0;
        bus.ready = 1'b0;

        for (int i = 0; i < 4; i++)
            run_cmd(tbl[i], 1'b0, $sformatf("vec%0d", i));

        run_cmd(tbl[4], 1'b1, "busy_start");

`ifdef LA_BUS_INITIATOR_TIMEOUT_EN
        begin
            int  vcnt = 0;
            bit  drop = 0;
            @(negedge clk);
            cmd_start = 1'b1;
            cmd_wstrb = 4'h0;
            cmd_len   = 4'd3;
            for (int c = 0; c < 64 && !drop; c++) begin
                @(negedge clk);
                cmd_start = 1'b0;
                if (bus.valid) vcnt++;
                else begin
                    drop = 1;
                    chk("tmo_done", 32'(done), 32'h1);
                end
            end
            chk("tmo_dropped", 32'(drop), 32'h1);
            chk("tmo_req_cycles", 32'(vcnt), 32'd16);
            chk("tmo_err", 32'(err), 32'h1);
            chk("tmo_beats", 32'(beats_done), 32'h0);
            chk("tmo_busy", 32'(busy), 32'h0);
            @(negedge clk);
            chk("tmo_done_pulse", 32'(done), 32'h0);
            chk("tmo_err_sticky", 32'(err), 32'h1);
            chk("tmo_no_retry", 32'(bus.valid), 32'h0);
        end
`else
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_wstrb = 4'h0;
        cmd_len   = 4'd0;
        @(negedge clk);
        cmd_start = 1'b0;
        repeat (100) @(negedge clk);
        chk("hold_valid", 32'(bus.valid), 32'h1);
        chk("hold_err", 32'(err), 32'h0);
        chk("hold_busy", 32'(busy), 32'h1);
        bus.ready = 1'b1;
        bus.rdata = 32'h0000_0077;
        @(negedge clk);
        bus.ready = 1'b0;
        chk("hold_done", 32'(done), 32'h1);
        chk("hold_beats", 32'(beats_done), 32'd1);
        chk("hold_rdata", last_rdata, 32'h0000_0077);
`endif

        // Reset in the second beat of a 4-beat burst
        begin
            int beat = 0;
            int rc   = 0;
            bit hit  = 0;
            @(negedge clk);
            cmd_start = 1'b1;
            cmd_wstrb = 4'hF;
            cmd_wdata = 32'h0000_1000;
            cmd_len   = 4'd3;
            for (int c = 0; c < 40 && !hit; c++) begin
                @(negedge clk);
                cmd_start = 1'b0;
                bus.ready = 1'b0;
                if (bus.valid) begin
                    if (beat == 1) begin
                        hit = 1;
                    end else if (rc == 1) begin
                        bus.ready = 1'b1;
                        bus.rdata = 32'h0000_0077;
                        beat++;
                        rc = 0;
                    end else begin
                        rc++;
                    end
                end
            end
            chk("midrst_reached_beat2", 32'(hit), 32'h1);
            chk("midrst_pre_rdata", last_rdata, 32'h0000_0077);
            reset     = 1'b1;
            cmd_start = 1'b1;
            bus.ready = 1'b1;
            @(negedge clk);
            check_reset_state("midrst");
            reset     = 1'b0;
            cmd_start = 1'b0;
            bus.ready = 1'b0;
            @(negedge clk);
            chk("midrst_stays_idle", 32'(busy), 32'h0);
        end

        run_cmd(tbl[2], 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
